tag_ctrl: RTL and testbench

- 2-way set-associative tag controller that sequences the two 32-entry x 22-bit tag SRAM macros.
- Serialises lookup, fill, line-invalidate and flush-all requests from the L1 cache FSM.
- Compares tags, chooses hit or victim way, and keeps per-set LRU bits in flops.
- Sits between the cache controller and the tag array wrapper. Shares one address/data bus to both ways, with a per-way write strobe.

---
 rtl/tag_ctrl_if.sv | 39 +++
 rtl/tag_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_tag_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tag_ctrl_if.sv
// Request/response handshake and tag SRAM bus for tag_ctrl.
// slave = the tag controller, master = the cache FSM plus the tag array wrapper.
interface tag_ctrl_if #(
  parameter int IDX_W = 5,
  parameter int TAG_W = 21
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_addr;
  logic             req_way;
  logic             resp_valid;
  logic             resp_hit;
  logic             resp_way;
  logic             resp_victim_valid;
  logic [TAG_W-1:0] resp_victim_tag;
  logic             busy;
  logic             ta_cs;
  logic             ta_oe;
  logic [1:0]       ta_web;
  logic [IDX_W-1:0] ta_a;
  logic [TAG_W:0]   ta_di;
  logic [TAG_W:0]   ta_do0;
  logic [TAG_W:0]   ta_do1;

  // Handshake: a request transfers on a rising edge where req_valid & req_ready;
  // the requester holds it stable until then. resp_valid is a one-cycle pulse
  // with no backpressure, exactly one per accepted request.
  modport slave (
    input  req_valid, req_op, req_addr, req_way, ta_do0, ta_do1,
    output req_ready, resp_valid, resp_hit, resp_way, resp_victim_valid,
           resp_victim_tag, busy, ta_cs, ta_oe, ta_web, ta_a, ta_di
  );
  modport master (
    output req_valid, req_op, req_addr, req_way, ta_do0, ta_do1,
    input  req_ready, resp_valid, resp_hit, resp_way, resp_victim_valid,
           resp_victim_tag, busy, ta_cs, ta_oe, ta_web, ta_a, ta_di
  );
endinterface

// File: rtl/tag_ctrl.sv
// 2-way set-associative tag controller: lookup/fill/invalidate/flush over two tag SRAMs.
// Optional TAG_CTRL_PERF_CNT_EN adds hit_cnt/miss_cnt lookup counters.
module tag_ctrl #(
  parameter int IDX_W = 5,
  parameter int TAG_W = 21,
  parameter int OFS_W = 6
) (
  input  logic       CK,
  input  logic       RSTn,
  tag_ctrl_if.slave  bus,
  output logic [1:0] dbg_state
`ifdef TAG_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int SETS = 1 << IDX_W;

  typedef enum logic [1:0] {INIT = 2'd0, IDLE = 2'd1, CMP = 2'd2, FLUSH = 2'd3} state_t;
  typedef enum logic [1:0] {OP_LOOKUP = 2'd0, OP_FILL = 2'd1, OP_INV = 2'd2, OP_FLUSH = 2'd3} op_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt;
  logic [SETS-1:0]  lru, lru_nxt;
  logic [IDX_W-1:0] idx_q;
  logic [TAG_W-1:0] tag_q;
  logic             pend_q, pend_nxt;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             hit0, hit1, victim;
  logic [TAG_W:0]   victim_ent;
  logic             ready, busy_o, cs, oe;
  logic [1:0]       web;
  logic [IDX_W-1:0] addr;
  logic [TAG_W:0]   di;
  logic             rv, rhit, rway, rvv;
  logic [TAG_W-1:0] rvtag;
  logic             unused_ok;

  assign req_idx   = bus.req_addr[OFS_W+IDX_W-1:OFS_W];
  assign req_tag   = bus.req_addr[31:OFS_W+IDX_W];
  assign unused_ok = ^bus.req_addr[OFS_W-1:0];

  assign hit0 = bus.ta_do0[TAG_W] & (bus.ta_do0[TAG_W-1:0] == tag_q);
  assign hit1 = bus.ta_do1[TAG_W] & (bus.ta_do1[TAG_W-1:0] == tag_q);
  // lru[set] names the way to evict next; invalid ways are always preferred.
  assign victim     = !bus.ta_do0[TAG_W] ? 1'b0 : (!bus.ta_do1[TAG_W] ? 1'b1 : lru[idx_q]);
  assign victim_ent = victim ? bus.ta_do1 : bus.ta_do0;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lru_nxt   = lru;
    pend_nxt  = 1'b0;
    ready     = 1'b0;
    busy_o    = 1'b1;
    cs        = 1'b0;
    oe        = 1'b0;
    web       = 2'b11;
    addr      = '0;
    di        = '0;
    rv        = pend_q;
    rhit      = 1'b0;
    rway      = 1'b0;
    rvv       = 1'b0;
    rvtag     = '0;
    case (state)
      INIT, FLUSH: begin
        cs      = 1'b1;
        web     = 2'b00;
        addr    = cnt;
        cnt_nxt = cnt + 1'b1;
        if (cnt == '1) begin
          lru_nxt   = '0;
          state_nxt = IDLE;
          pend_nxt  = (state == FLUSH);
        end
      end
      IDLE: begin
        ready  = 1'b1;
        busy_o = 1'b0;
        if (bus.req_valid) begin
          case (op_t'(bus.req_op))
            OP_LOOKUP: begin
              cs        = 1'b1;
              oe        = 1'b1;
              addr      = req_idx;
              state_nxt = CMP;
            end
            OP_FILL: begin
              cs                  = 1'b1;
              web[bus.req_way]    = 1'b0;
              addr                = req_idx;
              di                  = {1'b1, req_tag};
              lru_nxt[req_idx]    = ~bus.req_way;
              pend_nxt            = 1'b1;
            end
            OP_INV: begin
              cs                  = 1'b1;
              web[bus.req_way]    = 1'b0;
              addr                = req_idx;
              lru_nxt[req_idx]    = bus.req_way;
              pend_nxt            = 1'b1;
            end
            default: begin
              state_nxt = FLUSH;
              cnt_nxt   = '0;
            end
          endcase
        end
      end
      default: begin
        rv        = 1'b1;
        rhit      = hit0 | hit1;
        state_nxt = IDLE;
        if (hit0 | hit1) begin
          rway           = ~hit0;
          lru_nxt[idx_q] = hit0;
        end else begin
          rway  = victim;
          rvv   = victim_ent[TAG_W];
          rvtag = victim_ent[TAG_W-1:0];
        end
      end
    endcase
    // Hold the SRAM quiet while reset is asserted, even though state reads INIT.
    if (!RSTn) begin
      cs   = 1'b0;
      oe   = 1'b0;
      web  = 2'b11;
      addr = '0;
      di   = '0;
    end
  end

  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) begin
      state  <= INIT;
      cnt    <= '0;
      lru    <= '0;
      pend_q <= 1'b0;
      idx_q  <= '0;
      tag_q  <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      lru    <= lru_nxt;
      pend_q <= pend_nxt;
      if (state == IDLE && bus.req_valid && bus.req_op == OP_LOOKUP) begin
        idx_q <= req_idx;
        tag_q <= req_tag;
      end
    end
  end

`ifdef TAG_CTRL_PERF_CNT_EN
  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == CMP) begin
      if (hit0 | hit1) hit_cnt  <= hit_cnt + 32'd1;
      else             miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

  assign bus.req_ready         = ready;
  assign bus.busy              = busy_o;
  assign bus.ta_cs             = cs;
  assign bus.ta_oe             = oe;
  assign bus.ta_web            = web;
  assign bus.ta_a              = addr;
  assign bus.ta_di             = di;
  assign bus.resp_valid        = rv;
  assign bus.resp_hit          = rhit;
  assign bus.resp_way          = rway;
  assign bus.resp_victim_valid = rvv;
  assign bus.resp_victim_tag   = rvtag;
  assign dbg_state             = state;
endmodule

// File: tb/tb_tag_ctrl.sv
// Scoreboard bench for tag_ctrl: cache-level reference model, SRAM model, decoupled monitor.
module tb_tag_ctrl;
  logic CK = 1'b0;
  logic RSTn = 1'b0;
  always #5 CK = ~CK;

  tag_ctrl_if bus ();
  logic [1:0] dbg_state;
`ifdef TAG_CTRL_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  tag_ctrl dut (
    .CK(CK),
    .RSTn(RSTn),
    .bus(bus),
    .dbg_state(dbg_state)
`ifdef TAG_CTRL_PERF_CNT_EN
    ,
    .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
`endif
  );

  // Tag SRAM macros: read data appears the cycle after a read.
  logic [21:0] mem0 [32];
  logic [21:0] mem1 [32];
  initial begin
    for (int i = 0; i < 32; i++) begin
      mem0[i] = 22'($urandom);
      mem1[i] = 22'($urandom);
    end
  end
  always @(posedge CK) begin
    if (bus.ta_cs) begin
      if (!bus.ta_web[0]) mem0[bus.ta_a] <= bus.ta_di;
      if (!bus.ta_web[1]) mem1[bus.ta_a] <= bus.ta_di;
      if (bus.ta_oe) begin
        bus.ta_do0 <= mem0[bus.ta_a];
        bus.ta_do1 <= mem1[bus.ta_a];
      end
    end
  end

  int errors = 0;
  int checks = 0;
  // {is_lookup, hit, way, victim_valid, victim_tag[20:0]}
  logic [24:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: the cache contents as valid/tag per (set, way) and the way to evict next.
  logic        mv [32][2];
  logic [20:0] mt [32][2];
  logic        ml [32];
  int          exp_hits, exp_miss;

  task automatic model_clear();
    for (int s = 0; s < 32; s++) begin
      for (int w = 0; w < 2; w++) begin
        mv[s][w] = 1'b0;
        mt[s][w] = '0;
      end
      ml[s] = 1'b0;
    end
  endtask

  task automatic model_accept(input logic [1:0] op, input logic [31:0] addr, input logic way);
    int    idx;
    logic  [20:0] tag;
    logic  h0, h1;
    int    w;
    idx = int'(addr[10:6]);
    tag = addr[31:11];
    case (op)
      2'd0: begin
        h0 = mv[idx][0] && (mt[idx][0] == tag);
        h1 = mv[idx][1] && (mt[idx][1] == tag);
        if (h0 || h1) begin
          w = h0 ? 0 : 1;
          ml[idx] = (w == 0);
          exp_hits++;
          exp_q.push_back({1'b1, 1'b1, w[0], 1'b0, 21'd0});
        end else begin
          if (!mv[idx][0])      w = 0;
          else if (!mv[idx][1]) w = 1;
          else                  w = int'(ml[idx]);
          exp_miss++;
          exp_q.push_back({1'b1, 1'b0, w[0], mv[idx][w], mt[idx][w]});
        end
      end
      2'd1: begin
        mv[idx][way] = 1'b1;
        mt[idx][way] = tag;
        ml[idx] = ~way;
        exp_q.push_back(25'd0);
      end
      2'd2: begin
        mv[idx][way] = 1'b0;
        mt[idx][way] = '0;
        ml[idx] = way;
        exp_q.push_back(25'd0);
      end
      default: begin
        model_clear();
        exp_q.push_back(25'd0);
      end
    endcase
  endtask

  // Driver: called and returns on a falling edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic way);
    int waits;
    waits = 0;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_way   = way;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && waits < 200) begin
      @(negedge CK);
      waits++;
    end
    if (!bus.req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
    end else begin
      model_accept(op, addr, way);
      @(posedge CK);
      @(negedge CK);
      bus.req_valid = 1'b0;
      if (op != 2'd3) check("resp_latency", 32'(bus.resp_valid), 32'd1);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {bus.req_ready, bus.busy, bus.resp_valid, bus.ta_cs, bus.ta_oe,
                 bus.ta_web, bus.ta_a, bus.ta_di[19:0]},
          {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 5'd0, 20'd0});
    check({name, "_di"}, 32'(bus.ta_di), 32'd0);
  endtask

  // Monitor: pops one expectation per response pulse.
  logic [24:0] mon_e;
  always @(negedge CK) begin
    if (RSTn) begin
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e[24])
            check("lookup_resp", {8'd0, bus.resp_hit, bus.resp_way, bus.resp_victim_valid,
                                  bus.resp_victim_tag}, {8'd0, mon_e[23:0]});
          else
            check("ack_hit", 32'(bus.resp_hit), 32'd0);
        end
      end else begin
        check("quiet_resp_zero", {8'd0, bus.resp_hit, bus.resp_way, bus.resp_victim_valid,
                                  bus.resp_victim_tag}, 32'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int low;
    int waits;
    logic [1:0]  op;
    logic [31:0] addr;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'd0;
    bus.req_addr  = '0;
    bus.req_way   = 1'b0;
    exp_hits      = 0;
    exp_miss      = 0;
    model_clear();

    repeat (3) @(negedge CK);
    check_reset_outputs("reset_vals");
    RSTn = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      check("init_sweep", {bus.ta_cs, bus.ta_web, bus.ta_a, bus.req_ready, bus.busy},
            {1'b1, 2'b00, i[4:0], 1'b0, 1'b1});
      check("init_di", 32'(bus.ta_di), 32'd0);
      @(negedge CK);
    end
    check("init_done", {bus.req_ready, bus.busy}, {1'b1, 1'b0});

    // Directed: cold miss, fills, hit, LRU victim, invalidate.
    issue(2'd0, 32'h0000_1040, 1'b0);
    issue(2'd1, 32'h0000_1040, 1'b0);
    issue(2'd1, 32'h0000_2040, 1'b1);
    issue(2'd0, 32'h0000_1040, 1'b0);
    issue(2'd0, 32'h0000_3040, 1'b0);
    issue(2'd2, 32'h0000_1040, 1'b0);
    issue(2'd0, 32'h0000_1040, 1'b0);

    // Random traffic on a few sets and tags so hits, LRU and invalid ways all occur.
    repeat (300) begin
      case ($urandom_range(0, 49))
        0:                         op = 2'd3;
        1, 2, 3, 4, 5, 6, 7, 8:    op = 2'd2;
        default:                   op = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd1;
      endcase
      addr = {21'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 6'($urandom_range(0, 63))};
      issue(op, addr, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge CK);
    end

    // Flush: ready low for the whole sweep, then one response, then cold misses.
    issue(2'd1, 32'h0000_1040, 1'b0);
    issue(2'd1, 32'h0000_2040, 1'b1);
    issue(2'd3, 32'h0, 1'b0);
    low = 0;
    while (!bus.req_ready && low < 100) begin
      low++;
      @(negedge CK);
    end
    check("flush_ready_low", 32'(low), 32'd32);
    check("flush_resp", 32'(bus.resp_valid), 32'd1);
    issue(2'd0, 32'h0000_1040, 1'b0);
    issue(2'd0, 32'h0000_2040, 1'b0);

    waits = 0;
    while (exp_q.size() != 0 && waits < 100) begin
      @(negedge CK);
      waits++;
    end
    check("drain_pre_reset", 32'(exp_q.size()), 32'd0);
`ifdef TAG_CTRL_PERF_CNT_EN
    check("hit_cnt", hit_cnt, 32'(exp_hits));
    check("miss_cnt", miss_cnt, 32'(exp_miss));
`endif

    // Reset mid-flush with a lookup held pending.
    issue(2'd1, 32'h0000_1040, 1'b0);
    issue(2'd3, 32'h0, 1'b0);
    bus.req_op    = 2'd0;
    bus.req_addr  = 32'h0000_1040;
    bus.req_way   = 1'b0;
    bus.req_valid = 1'b1;
    waits = 0;
    while (bus.ta_a != 5'd10 && waits < 100) begin
      @(negedge CK);
      waits++;
    end
    check("reach_cnt10", 32'(bus.ta_a), 32'd10);
    RSTn = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    model_clear();
    exp_hits = 0;
    exp_miss = 0;
    @(negedge CK);
    @(negedge CK);
    RSTn = 1'b1;
    #1;
    check("restart_sweep", {bus.ta_cs, bus.ta_web, bus.ta_a, bus.req_ready},
          {1'b1, 2'b00, 5'd0, 1'b0});
    low = 0;
    while (!bus.req_ready && low < 100) begin
      low++;
      @(negedge CK);
    end
    check("reinit_ready_low", 32'(low), 32'd32);
    model_accept(2'd0, 32'h0000_1040, 1'b0);
    @(posedge CK);
    @(negedge CK);
    bus.req_valid = 1'b0;
    check("pending_lookup_resp", 32'(bus.resp_valid), 32'd1);

    repeat (3) @(negedge CK);
    check("drain_final", 32'(exp_q.size()), 32'd0);
`ifdef TAG_CTRL_PERF_CNT_EN
    check("hit_cnt_after_reset", hit_cnt, 32'(exp_hits));
    check("miss_cnt_after_reset", miss_cnt, 32'(exp_miss));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
